// File: rtl/mau_pkg.sv
// mau_pkg: shared types and helpers for the MAU decode stage.
//   op_e        : 4-bit opcode enum (codes 6..15 are illegal)
//   dec_state_e : decode FSM states
//   is_legal()  : true for opcodes that name a real ALU operation (NOP excluded)
//   is_nop()    : true for the NOP opcode
package mau_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 4'd0,
      OP_ADD   = 4'd1,
      OP_SUB   = 4'd2,
      OP_MUL   = 4'd3,
      OP_DOT   = 4'd4,   // a1*b1 + a2*b2
      OP_SCALE = 4'd5    // a * b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      ISSUE  = 2'd2,
      DRAIN  = 2'd3
   } dec_state_e;

   function automatic logic is_legal(input logic [OP_W-1:0] code);
      return (code >= 4'd1) && (code <= 4'd5);
   endfunction

   function automatic logic is_nop(input logic [OP_W-1:0] code);
      return code == 4'd0;
   endfunction

endpackage

// File: rtl/decode_4b_if.sv
// decode_4b_if: bundles the RX-side instruction handshake and the ALU-side
// issue handshake of the decode stage.
//   RX side : rx_valid, op, a1, a2, b1, b2 (to decode), alu_ready (from decode)
//   ALU side: dec_valid, dec_op, dec_a1..dec_b2, dec_err, issued_cnt (from decode),
//             dec_ready (to decode)
//   master  : the environment (RX stage + ALU)
//   slave   : the decode stage
interface decode_4b_if #(
   parameter int NIB_W = 4,
   parameter int CNT_W = 8
);
   import mau_pkg::*;

   logic             rx_valid;
   logic [NIB_W-1:0] op;
   logic [NIB_W-1:0] a1;
   logic [NIB_W-1:0] a2;
   logic [NIB_W-1:0] b1;
   logic [NIB_W-1:0] b2;
   logic             alu_ready;

   logic             dec_valid;
   logic             dec_ready;
   op_e              dec_op;
   logic [NIB_W-1:0] dec_a1;
   logic [NIB_W-1:0] dec_a2;
   logic [NIB_W-1:0] dec_b1;
   logic [NIB_W-1:0] dec_b2;
   logic             dec_err;
   logic [CNT_W-1:0] issued_cnt;

   modport master (
      output rx_valid, op, a1, a2, b1, b2, dec_ready,
      input  alu_ready, dec_valid, dec_op, dec_a1, dec_a2, dec_b1, dec_b2,
             dec_err, issued_cnt
   );

   modport slave (
      input  rx_valid, op, a1, a2, b1, b2, dec_ready,
      output alu_ready, dec_valid, dec_op, dec_a1, dec_a2, dec_b1, dec_b2,
             dec_err, issued_cnt
   );

endinterface

// File: rtl/decode_4b.sv
// decode_4b: decode stage of the MAU pipeline.
// Takes one instruction from RX while IDLE, classifies its opcode, drops NOPs
// (when SKIP_NOP=1) and illegal opcodes, and issues the rest to the ALU over a
// valid/ready handshake. All ALU-side outputs are registered; alu_ready is
// combinational (high only in IDLE).
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : decode_4b_if.slave (RX instruction handshake + ALU issue handshake)
module decode_4b
   import mau_pkg::*;
#(
   parameter int NIB_W    = 4,
   parameter int CNT_W    = 8,
   parameter bit SKIP_NOP = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   decode_4b_if.slave  bus
);

   dec_state_e       state_q, state_d;
   logic [NIB_W-1:0] op_q, op_d;
   logic [NIB_W-1:0] a1_q, a1_d, a2_q, a2_d, b1_q, b1_d, b2_q, b2_d;
   op_e              dec_op_q, dec_op_d;
   logic             dec_valid_q, dec_valid_d;
   logic             dec_err_q, dec_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic legal_w;
   logic nop_w;
   logic issue_w;
   logic handshake_w;

   // Opcode classification of the instruction latched in IDLE.
   assign legal_w     = is_legal(op_q);
   assign nop_w       = is_nop(op_q);
   assign issue_w     = legal_w || (nop_w && !SKIP_NOP);
   assign handshake_w = dec_valid_q && bus.dec_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.rx_valid) state_d = DECODE;
         DECODE:  state_d = issue_w ? ISSUE : DRAIN;
         ISSUE:   if (handshake_w) state_d = DRAIN;
         // Holding here until RX drops rx_valid keeps one instruction from
         // being captured twice.
         DRAIN:   if (!bus.rx_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next-state logic
   always_comb begin
      op_d        = op_q;
      a1_d        = a1_q;
      a2_d        = a2_q;
      b1_d        = b1_q;
      b2_d        = b2_q;
      dec_op_d    = dec_op_q;
      dec_valid_d = dec_valid_q;
      dec_err_d   = 1'b0;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.rx_valid) begin
               op_d = bus.op;
               a1_d = bus.a1;
               a2_d = bus.a2;
               b1_d = bus.b1;
               b2_d = bus.b2;
            end
         end
         DECODE: begin
            if (issue_w) begin
               dec_valid_d = 1'b1;
               dec_op_d    = op_e'(op_q);
            end else if (!nop_w) begin
               dec_err_d = 1'b1;
            end
         end
         ISSUE: begin
            if (handshake_w) begin
               dec_valid_d = 1'b0;
               cnt_d       = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and latched instruction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q        <= '0;
         a1_q        <= '0;
         a2_q        <= '0;
         b1_q        <= '0;
         b2_q        <= '0;
         dec_op_q    <= OP_NOP;
         dec_valid_q <= 1'b0;
         dec_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         op_q        <= op_d;
         a1_q        <= a1_d;
         a2_q        <= a2_d;
         b1_q        <= b1_d;
         b2_q        <= b2_d;
         dec_op_q    <= dec_op_d;
         dec_valid_q <= dec_valid_d;
         dec_err_q   <= dec_err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.alu_ready  = (state_q == IDLE);
   assign bus.dec_valid  = dec_valid_q;
   assign bus.dec_op     = dec_op_q;
   assign bus.dec_a1     = a1_q;
   assign bus.dec_a2     = a2_q;
   assign bus.dec_b1     = b1_q;
   assign bus.dec_b2     = b2_q;
   assign bus.dec_err    = dec_err_q;
   assign bus.issued_cnt = cnt_q;

endmodule

// File: tb/tb_decode_4b.sv
// tb_decode_4b: self-checking bench for decode_4b.
// Two instances share one stimulus set: u_skip (SKIP_NOP=1) and u_keep
// (SKIP_NOP=0); sel routes rx_valid to one of them and selects whose outputs
// are observed. Expected results come from a transaction-level model: the
// opcode class decides issue/error, and the cycle at which each event should
// appear is computed from the hold and stall lengths chosen for the transaction.
module tb_decode_4b;
   import mau_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       sel;
   logic       rx_valid;
   logic       dec_ready;
   logic [3:0] op, a1, a2, b1, b2;

   decode_4b_if #(.NIB_W(4), .CNT_W(8)) if0 ();
   decode_4b_if #(.NIB_W(4), .CNT_W(8)) if1 ();

   assign if0.rx_valid  = rx_valid & ~sel;
   assign if1.rx_valid  = rx_valid & sel;
   assign if0.op = op;  assign if0.a1 = a1;  assign if0.a2 = a2;
   assign if0.b1 = b1;  assign if0.b2 = b2;
   assign if1.op = op;  assign if1.a1 = a1;  assign if1.a2 = a2;
   assign if1.b1 = b1;  assign if1.b2 = b2;
   assign if0.dec_ready = dec_ready;
   assign if1.dec_ready = dec_ready;

   decode_4b #(.NIB_W(4), .CNT_W(8), .SKIP_NOP(1'b1)) u_skip (
      .clk(clk), .rst_n(rst_n), .bus(if0));
   decode_4b #(.NIB_W(4), .CNT_W(8), .SKIP_NOP(1'b0)) u_keep (
      .clk(clk), .rst_n(rst_n), .bus(if1));

   // Observed outputs of the selected instance
   logic       m_alu_ready, m_dec_valid, m_dec_err;
   logic [3:0] m_dec_op, m_a1, m_a2, m_b1, m_b2;
   logic [7:0] m_cnt;
   assign m_alu_ready = sel ? if1.alu_ready  : if0.alu_ready;
   assign m_dec_valid = sel ? if1.dec_valid  : if0.dec_valid;
   assign m_dec_err   = sel ? if1.dec_err    : if0.dec_err;
   assign m_dec_op    = sel ? if1.dec_op     : if0.dec_op;
   assign m_a1        = sel ? if1.dec_a1     : if0.dec_a1;
   assign m_a2        = sel ? if1.dec_a2     : if0.dec_a2;
   assign m_b1        = sel ? if1.dec_b1     : if0.dec_b1;
   assign m_b2        = sel ? if1.dec_b2     : if0.dec_b2;
   assign m_cnt       = sel ? if1.issued_cnt : if0.issued_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int model_cnt [2];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // One instruction: offered while the selected instance is idle, rx_valid
   // kept high for hold extra cycles after the accept edge, and dec_ready kept
   // low for stall cycles of dec_valid before being raised.
   task automatic run_txn(input logic s, input logic [3:0] t_op, input logic [3:0] t_a1,
                          input logic [3:0] t_a2, input logic [3:0] t_b1,
                          input logic [3:0] t_b2, input int hold, input int stall);
      bit         exp_issue, exp_err, ok_ops;
      int         first_v, vcyc, errs, ret_k, exp_ret, d_k, n;
      logic [3:0] first_op;
      exp_err   = (t_op > 4'd5);
      exp_issue = ((t_op >= 4'd1) && (t_op <= 4'd5)) || ((t_op == 4'd0) && s);
      sel = s;
      #1;
      n = 0;
      while (!m_alu_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("idle_ready", 32'(m_alu_ready), 32'd1);
      rx_valid = 1'b1;
      op = t_op; a1 = t_a1; a2 = t_a2; b1 = t_b1; b2 = t_b2;
      dec_ready = exp_issue ? (stall == 0) : 1'($urandom);
      first_v = -1; vcyc = 0; errs = 0; ret_k = -1; ok_ops = 1'b1; first_op = '0;
      for (int k = 1; k <= 60 && ret_k < 0; k++) begin
         @(negedge clk);
         if (m_dec_valid) begin
            if (first_v < 0) begin
               first_v  = k;
               first_op = m_dec_op;
            end
            vcyc++;
            if ({m_a1, m_a2, m_b1, m_b2} !== {t_a1, t_a2, t_b1, t_b2}) ok_ops = 1'b0;
         end
         if (m_dec_err) errs++;
         if (m_alu_ready) ret_k = k;
         if (k == hold + 1) rx_valid = 1'b0;
         // Inputs outside IDLE must be ignored, so scramble them.
         op = 4'($urandom); a1 = 4'($urandom); a2 = 4'($urandom);
         b1 = 4'($urandom); b2 = 4'($urandom);
         if (exp_issue) dec_ready = (first_v >= 0) ? ((k - first_v) >= stall) : (stall == 0);
         else           dec_ready = 1'($urandom);
      end
      rx_valid = 1'b0;
      d_k     = exp_issue ? (3 + stall) : 2;
      exp_ret = (d_k + 1 > hold + 2) ? d_k + 1 : hold + 2;
      check("return_idle_cycle", 32'(ret_k), 32'(exp_ret));
      check("first_valid_cycle", 32'(first_v), exp_issue ? 32'd2 : 32'hFFFF_FFFF);
      check("valid_cycles", 32'(vcyc), exp_issue ? 32'(stall + 1) : 32'd0);
      check("err_pulses", 32'(errs), exp_err ? 32'd1 : 32'd0);
      if (exp_issue) begin
         check("operands", 32'(ok_ops), 32'd1);
         check("dec_op", 32'(first_op), 32'(t_op));
      end
      model_cnt[s] = (model_cnt[s] + int'(exp_issue)) % 256;
      check("issued_cnt", 32'(m_cnt), 32'(model_cnt[s]));
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; rx_valid = 1'b0; dec_ready = 1'b0;
      op = '0; a1 = '0; a2 = '0; b1 = '0; b2 = '0;
      model_cnt[0] = 0; model_cnt[1] = 0;
      repeat (3) @(negedge clk);
      check("rst_alu_ready", 32'(if0.alu_ready), 32'd1);
      check("rst_dec_valid", 32'(if0.dec_valid), 32'd0);
      check("rst_dec_err", 32'(if0.dec_err), 32'd0);
      check("rst_cnt", 32'(if0.issued_cnt), 32'd0);
      check("rst_dec_op", 32'(if1.dec_op), 32'd0);
      check("rst_operands", 32'({if1.dec_a1, if1.dec_a2, if1.dec_b1, if1.dec_b2}), 32'd0);
      rst_n = 1'b1;

      // Directed cases
      run_txn(1'b0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 0, 0);   // ADD, immediate accept
      run_txn(1'b0, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10, 0, 5);  // DOT, 5-cycle stall
      run_txn(1'b0, 4'd9, 4'd1, 4'd2, 4'd3, 4'd4, 0, 0);   // illegal
      run_txn(1'b0, 4'd15, 4'd1, 4'd2, 4'd3, 4'd4, 1, 0);  // illegal, top code
      run_txn(1'b0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 0, 0);   // NOP skipped
      run_txn(1'b1, 4'd0, 4'd5, 4'd6, 4'd7, 4'd8, 0, 0);   // NOP issued
      run_txn(1'b0, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 3, 0);   // rx_valid held 3 cycles
      run_txn(1'b1, 4'd5, 4'd9, 4'd0, 4'd3, 4'd12, 3, 2);
      run_txn(1'b0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 3, 0);   // first illegal code

      // Reset while an instruction waits in ISSUE
      @(negedge clk);
      sel = 1'b0; rx_valid = 1'b1; dec_ready = 1'b0;
      op = 4'd3; a1 = 4'd11; a2 = 4'd12; b1 = 4'd13; b2 = 4'd14;
      @(negedge clk);
      rx_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", 32'(m_dec_valid), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", 32'(m_dec_valid), 32'd0);
      check("mid_rst_cnt", 32'(m_cnt), 32'd0);
      check("mid_rst_ready", 32'(m_alu_ready), 32'd1);
      check("mid_rst_operands", 32'({m_a1, m_a2, m_b1, m_b2}), 32'd0);
      rst_n = 1'b1;
      model_cnt[0] = 0; model_cnt[1] = 0;

      // Randomized transactions
      for (int i = 0; i < 80; i++) begin
         run_txn(1'($urandom), ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 5))
                                                          : 4'($urandom),
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Counter wrap: 256 issues from zero
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_cnt[0] = 0; model_cnt[1] = 0;
      for (int i = 0; i < 256; i++) begin
         run_txn(1'b0, 4'($urandom_range(1, 5)), 4'($urandom), 4'($urandom),
                 4'($urandom), 4'($urandom), 0, 0);
      end
      check("cnt_wrap", 32'(m_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
